// File: rtl/timekeeper_if.sv
// Control and display bundle between the board top level and timekeeper_core.
// The board drives the master side; the core sits on the slave side.
interface timekeeper_if #(
    parameter int START_W = 10,
    parameter int LED_W   = 7
);
    logic               mode_next;
    logic               run;
    logic               load;
    logic [START_W-1:0] preset_sec;
    logic [4:0]         preset_hour;
    logic [5:0]         preset_min;
    logic [2:0]         mode_led;
    logic [23:0]        digits;
    logic               done;
    logic               tick;
    logic [LED_W-1:0]   lights;

    modport master (
        output mode_next, run, load,
        output preset_sec, preset_hour, preset_min,
        input  mode_led, digits, done, tick, lights
    );

    modport slave (
        input  mode_next, run, load,
        input  preset_sec, preset_hour, preset_min,
        output mode_led, digits, done, tick, lights
    );
endinterface

// File: rtl/timekeeper_core.sv
// Three-mode timekeeper: countdown timer, 24 h stopwatch, 12 h wall clock.
// Define TIMEKEEPER_ALARM_EN to build the flash prescaler driving lights.
module timekeeper_core #(
    parameter int CLK_HZ   = 50_000_000,
    parameter int TICK_HZ  = 1,
    parameter int FLASH_HZ = 4,
    parameter int START_W  = 10,
    parameter int LED_W    = 7
) (
    input  logic        clk,
    input  logic        reset,
    timekeeper_if.slave bus
);

    typedef enum logic [1:0] {
        M_TIMER,
        M_SWATCH,
        M_CLOCK
    } mode_t;

    localparam int TICK_DIV = CLK_HZ / TICK_HZ;
    localparam int TW       = $clog2(TICK_DIV);
    localparam int CW       = $clog2(START_W + 1);

    mode_t              mode_q;
    mode_t              mode_d;
    logic [2:0]         mode_led;

    logic [TW-1:0]      tcnt;
    logic               tick;

    logic               load_ok;
    logic               tmr_load;
    logic               sw_load;
    logic               clk_load;
    logic               tmr_step;
    logic               sw_step;

    logic [START_W-1:0] tmr_count;
    logic               tmr_done;

    logic [4:0]         sw_hour;
    logic [5:0]         sw_min;
    logic [5:0]         sw_sec;

    logic [3:0]         clk_hour;
    logic [5:0]         clk_min;
    logic [5:0]         clk_sec;

    logic               busy;
    logic               cnv_done;
    logic [START_W-1:0] cnv_src;
    logic [START_W-1:0] cnv_sh;
    logic [23:0]        cnv_bcd;
    logic [23:0]        bcd_adj;
    logic [CW-1:0]      cnv_left;

    logic [23:0]        digits_q;

    function automatic logic [7:0] split(input logic [5:0] v);
        logic [5:0] t;
        logic [5:0] u;
        t = v / 6'd10;
        u = v % 6'd10;
        return {t[3:0], u[3:0]};
    endfunction

    // Fold a 0..31 hour preset onto the 1..12 dial.
    function automatic logic [3:0] map_hour(input logic [4:0] h);
        logic [4:0] t;
        t = h - 5'd12;
        if (h == 5'd0 || h > 5'd23) return 4'd12;
        if (h <= 5'd12) return h[3:0];
        return t[3:0];
    endfunction

    // Tick prescaler
    assign tick = (tcnt == TW'(TICK_DIV - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tcnt <= '0;
        end else begin
            tcnt <= tick ? '0 : tcnt + 1'b1;
        end
    end

    // Mode FSM
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mode_q <= M_TIMER;
        end else begin
            mode_q <= mode_d;
        end
    end

    always_comb begin
        mode_d   = mode_q;
        mode_led = 3'b000;
        if (bus.mode_next) begin
            unique case (mode_q)
                M_TIMER:  mode_d = M_SWATCH;
                M_SWATCH: mode_d = M_CLOCK;
                default:  mode_d = M_TIMER;
            endcase
        end
        unique case (mode_q)
            M_TIMER:  mode_led = 3'b001;
            M_SWATCH: mode_led = 3'b010;
            default:  mode_led = 3'b100;
        endcase
    end

    // A mode change swallows a coincident load.
    assign load_ok  = bus.load & ~bus.mode_next;
    assign tmr_load = load_ok & (mode_q == M_TIMER);
    assign sw_load  = load_ok & (mode_q == M_SWATCH);
    assign clk_load = load_ok & (mode_q == M_CLOCK);
    assign tmr_step = tick & bus.run & (mode_q == M_TIMER) & ~tmr_load;
    assign sw_step  = tick & bus.run & (mode_q == M_SWATCH) & ~sw_load;

    // Countdown timer
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tmr_count <= '0;
            tmr_done  <= 1'b0;
        end else if (tmr_load) begin
            tmr_count <= bus.preset_sec;
            tmr_done  <= 1'b0;
        end else if (tmr_step && tmr_count != '0) begin
            tmr_count <= tmr_count - 1'b1;
            if (tmr_count == START_W'(1)) begin
                tmr_done <= 1'b1;
            end
        end
    end

    // Stopwatch
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sw_hour <= '0;
            sw_min  <= '0;
            sw_sec  <= '0;
        end else if (sw_load) begin
            sw_hour <= '0;
            sw_min  <= '0;
            sw_sec  <= '0;
        end else if (sw_step) begin
            if (sw_sec == 6'd59) begin
                sw_sec <= '0;
                if (sw_min == 6'd59) begin
                    sw_min  <= '0;
                    sw_hour <= (sw_hour == 5'd23) ? 5'd0 : sw_hour + 5'd1;
                end else begin
                    sw_min <= sw_min + 6'd1;
                end
            end else begin
                sw_sec <= sw_sec + 6'd1;
            end
        end
    end

    // Wall clock runs on every tick whatever the mode or run level.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            clk_hour <= 4'd12;
            clk_min  <= '0;
            clk_sec  <= '0;
        end else if (clk_load) begin
            clk_hour <= map_hour(bus.preset_hour);
            clk_min  <= (bus.preset_min > 6'd59) ? 6'd59 : bus.preset_min;
            clk_sec  <= '0;
        end else if (tick) begin
            if (clk_sec == 6'd59) begin
                clk_sec <= '0;
                if (clk_min == 6'd59) begin
                    clk_min  <= '0;
                    clk_hour <= (clk_hour == 4'd12) ? 4'd1 : clk_hour + 4'd1;
                end else begin
                    clk_min <= clk_min + 6'd1;
                end
            end else begin
                clk_sec <= clk_sec + 6'd1;
            end
        end
    end

    always_comb begin
        bcd_adj = cnv_bcd;
        for (int i = 0; i < 6; i++) begin
            if (cnv_bcd[i*4 +: 4] >= 4'd5) begin
                bcd_adj[i*4 +: 4] = cnv_bcd[i*4 +: 4] + 4'd3;
            end
        end
    end

    // Shift-add-3 converter, free running; a new count restarts it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy     <= 1'b0;
            cnv_done <= 1'b0;
            cnv_src  <= '0;
            cnv_sh   <= '0;
            cnv_bcd  <= '0;
            cnv_left <= '0;
        end else begin
            cnv_done <= 1'b0;
            if (!busy || cnv_src != tmr_count) begin
                busy     <= 1'b1;
                cnv_src  <= tmr_count;
                cnv_sh   <= tmr_count;
                cnv_bcd  <= '0;
                cnv_left <= CW'(START_W);
            end else begin
                cnv_sh   <= cnv_sh << 1;
                cnv_bcd  <= {bcd_adj[22:0], cnv_sh[START_W-1]};
                cnv_left <= cnv_left - 1'b1;
                if (cnv_left == CW'(1)) begin
                    busy     <= 1'b0;
                    cnv_done <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            digits_q <= '0;
        end else begin
            unique case (mode_q)
                M_TIMER: begin
                    if (cnv_done) begin
                        digits_q <= cnv_bcd;
                    end
                end
                M_SWATCH: begin
                    digits_q <= {split({1'b0, sw_hour}),
                                 split(sw_min),
                                 split(sw_sec)};
                end
                default: begin
                    digits_q <= {split({2'b00, clk_hour}),
                                 split(clk_min),
                                 split(clk_sec)};
                end
            endcase
        end
    end

`ifdef TIMEKEEPER_ALARM_EN
    localparam int FLASH_DIV = CLK_HZ / FLASH_HZ;
    localparam int FW        = $clog2(FLASH_DIV);

    logic [FW-1:0]    fcnt;
    logic             flash_en;
    logic [LED_W-1:0] lights_q;

    assign flash_en = (fcnt == FW'(FLASH_DIV - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fcnt     <= '0;
            lights_q <= '0;
        end else begin
            fcnt <= flash_en ? '0 : fcnt + 1'b1;
            if (mode_q == M_TIMER && tmr_done) begin
                if (flash_en) begin
                    lights_q <= ~lights_q;
                end
            end else begin
                lights_q <= '0;
            end
        end
    end

    assign bus.lights = lights_q;
`else
    // FLASH_HZ has no role without the alarm flasher.
    logic [31:0] unused_flash;
    assign unused_flash = FLASH_HZ;
    assign bus.lights   = '0;
`endif

    assign bus.mode_led = mode_led;
    assign bus.digits   = digits_q;
    assign bus.done     = tmr_done;
    assign bus.tick     = tick;

endmodule

// File: tb/tb_timekeeper_core.sv
// Directed bench for timekeeper_core at CLK_HZ=8, TICK_HZ=1, FLASH_HZ=4.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_timekeeper_core;

    logic clk;
    logic reset;
    int   errors;
    int   checks;
    logic [6:0] fl [6];

    timekeeper_if #(.START_W(10), .LED_W(7)) tkif ();

    timekeeper_core #(
        .CLK_HZ  (8),
        .TICK_HZ (1),
        .FLASH_HZ(4),
        .START_W (10),
        .LED_W   (7)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (tkif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_tick();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (tkif.tick !== 1'b1 && n < 64);
        if (tkif.tick !== 1'b1) check("tick_timeout", 32'(tkif.tick), 32'd1);
    endtask

    task automatic mode_step();
        tkif.mode_next = 1'b1;
        cyc(1);
        tkif.mode_next = 1'b0;
    endtask

    task automatic pulse_load();
        tkif.load = 1'b1;
        cyc(1);
        tkif.load = 1'b0;
    endtask

    task automatic clk_load(input logic [4:0] h, input logic [5:0] m,
                            input logic [23:0] exp, input string tag);
        wait_tick();
        tkif.preset_hour = h;
        tkif.preset_min  = m;
        tkif.load        = 1'b1;
        cyc(1);
        tkif.load = 1'b0;
        cyc(1);
        check(tag, 32'(tkif.digits), 32'(exp));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: bench did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        errors           = 0;
        checks           = 0;
        reset            = 1'b1;
        tkif.mode_next   = 1'b0;
        tkif.run         = 1'b0;
        tkif.load        = 1'b0;
        tkif.preset_sec  = '0;
        tkif.preset_hour = '0;
        tkif.preset_min  = '0;
        cyc(3);
        check("rst_mode", 32'(tkif.mode_led), 32'h1);
        check("rst_digits", 32'(tkif.digits), 32'h0);
        check("rst_done", 32'(tkif.done), 32'h0);
        check("rst_lights", 32'(tkif.lights), 32'h0);
        check("rst_tick", 32'(tkif.tick), 32'h0);

        // 40 cycles after release: ticks at 8, 16, 24, 32, 40
        reset = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            check($sformatf("tick_c%0d", c), 32'(tkif.tick), 32'(c % 8 == 0));
            cyc(1);
        end
        tkif.mode_next = 1'b1;
        cyc(1);
        check("mode_sw", 32'(tkif.mode_led), 32'h2);
        cyc(1);
        tkif.mode_next = 1'b0;
        check("mode_clk", 32'(tkif.mode_led), 32'h4);
        cyc(1);
        check("clk_after40", 32'(tkif.digits), 32'h120005);

        // Clock loads and 12:59:59 rollover, run held low
        clk_load(5'd0, 6'd59, 24'h125900, "clk_h0");
        repeat (60) wait_tick();
        cyc(2);
        check("clk_roll", 32'(tkif.digits), 32'h010000);
        clk_load(5'd13, 6'd63, 24'h015900, "clk_h13");
        clk_load(5'd24, 6'd0, 24'h120000, "clk_h24");
        clk_load(5'd31, 6'd30, 24'h123000, "clk_h31");
        clk_load(5'd7, 6'd5, 24'h070500, "clk_h7");
        clk_load(5'd12, 6'd10, 24'h121000, "clk_h12");

        // Stopwatch
        mode_step();
        mode_step();
        cyc(1);
        check("sw_mode", 32'(tkif.mode_led), 32'h2);
        check("sw_zero", 32'(tkif.digits), 32'h0);
        tkif.run = 1'b1;
        repeat (60) wait_tick();
        cyc(2);
        check("sw_min_carry", 32'(tkif.digits), 32'h000100);
        tkif.run = 1'b0;
        force dut.sw_hour = 5'd23;
        force dut.sw_min  = 6'd59;
        force dut.sw_sec  = 6'd58;
        cyc(1);
        release dut.sw_hour;
        release dut.sw_min;
        release dut.sw_sec;
        cyc(1);
        check("sw_preset", 32'(tkif.digits), 32'h235958);
        tkif.run = 1'b1;
        wait_tick();
        cyc(2);
        check("sw_235959", 32'(tkif.digits), 32'h235959);
        wait_tick();
        cyc(2);
        check("sw_wrap", 32'(tkif.digits), 32'h000000);
        wait_tick();
        cyc(2);
        check("sw_000001", 32'(tkif.digits), 32'h000001);
        tkif.run = 1'b0;
        repeat (3) wait_tick();
        cyc(2);
        check("sw_hold", 32'(tkif.digits), 32'h000001);
        pulse_load();
        cyc(1);
        check("sw_clear", 32'(tkif.digits), 32'h0);

        // Timer display conversion
        mode_step();
        mode_step();
        cyc(14);
        check("tmr_mode", 32'(tkif.mode_led), 32'h1);
        check("tmr_zero", 32'(tkif.digits), 32'h0);
        tkif.preset_sec = 10'd999;
        pulse_load();
        cyc(11);
        check("bcd_lat_old", 32'(tkif.digits), 32'h0);
        cyc(1);
        check("bcd_999", 32'(tkif.digits), 32'h000999);
        tkif.preset_sec = 10'd1023;
        pulse_load();
        cyc(12);
        check("bcd_1023", 32'(tkif.digits), 32'h001023);
        tkif.preset_sec = 10'd3;
        pulse_load();
        cyc(12);
        check("bcd_3", 32'(tkif.digits), 32'h000003);

        // Countdown 3, 2, 1, 0
        tkif.run = 1'b1;
        wait_tick();
        cyc(1);
        check("tmr_2_done", 32'(tkif.done), 32'h0);
        wait_tick();
        cyc(1);
        check("tmr_1_done", 32'(tkif.done), 32'h0);
        wait_tick();
        check("tmr_pre0_done", 32'(tkif.done), 32'h0);
        cyc(1);
        check("tmr_0_done", 32'(tkif.done), 32'h1);
        cyc(11);
        check("tmr_lat_old", 32'(tkif.digits), 32'h000003);
        cyc(1);
        check("tmr_lat_new", 32'(tkif.digits), 32'h0);
        for (int i = 0; i < 6; i++) begin
            fl[i] = tkif.lights;
            cyc(1);
        end
`ifdef TIMEKEEPER_ALARM_EN
        for (int i = 0; i < 4; i++) begin
            check($sformatf("flash_%0d", i), 32'(fl[i+2]), 32'(fl[i] ^ 7'h7F));
        end
        check("flash_on_a", 32'(fl[0] | fl[2]), 32'h7F);
        check("flash_on_b", 32'(fl[1] | fl[3]), 32'h7F);
`else
        for (int i = 0; i < 6; i++) begin
            check($sformatf("lights_off_%0d", i), 32'(fl[i]), 32'h0);
        end
`endif
        wait_tick();
        cyc(1);
        tkif.run = 1'b0;
        cyc(13);
        check("tmr_hold_0", 32'(tkif.digits), 32'h0);
        check("tmr_hold_done", 32'(tkif.done), 32'h1);
        tkif.preset_sec = 10'd0;
        pulse_load();
        check("tmr_clr_done", 32'(tkif.done), 32'h0);
        cyc(1);
        check("tmr_clr_lights", 32'(tkif.lights), 32'h0);
        tkif.run = 1'b1;
        repeat (2) wait_tick();
        cyc(1);
        check("tmr_load0_done", 32'(tkif.done), 32'h0);
        tkif.run = 1'b0;

        // mode_next and load together: mode wins, count untouched
        tkif.preset_sec = 10'd5;
        pulse_load();
        cyc(12);
        check("tmr_5", 32'(tkif.digits), 32'h000005);
        tkif.preset_sec = 10'd9;
        tkif.mode_next  = 1'b1;
        tkif.load       = 1'b1;
        cyc(1);
        tkif.mode_next = 1'b0;
        tkif.load      = 1'b0;
        check("both_mode", 32'(tkif.mode_led), 32'h2);
        mode_step();
        mode_step();
        cyc(13);
        check("both_count", 32'(tkif.digits), 32'h000005);

        // Asynchronous reset mid-countdown
        pulse_load();
        cyc(12);
        check("tmr_9", 32'(tkif.digits), 32'h000009);
        tkif.run = 1'b1;
        wait_tick();
        cyc(3);
        #2 reset = 1'b1;
        #1;
        check("arst_digits", 32'(tkif.digits), 32'h0);
        check("arst_mode", 32'(tkif.mode_led), 32'h1);
        check("arst_done", 32'(tkif.done), 32'h0);
        check("arst_lights", 32'(tkif.lights), 32'h0);
        check("arst_tick", 32'(tkif.tick), 32'h0);
        @(negedge clk);
        reset    = 1'b0;
        tkif.run = 1'b0;
        mode_step();
        mode_step();
        cyc(1);
        check("arst_clock", 32'(tkif.digits), 32'h120000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/timekeeper_core.md
# timekeeper_core

Parametrised three-mode timekeeper: countdown timer, 24 h stopwatch and free-running 12 h wall clock, with a shared one-hot mode indicator, six BCD display digits and an alarm flash output. It sits between the debounced push-button/switch inputs and the six seven-segment decoders on the board top level. It generates its own tick and flash enables from `clk`, so no derived clocks are used.

## Interface
- `CLK_HZ`, 50_000_000, input clock frequency.
- `TICK_HZ`, 1, count rate. `CLK_HZ/TICK_HZ` must be an integer ≥ 2.
- `FLASH_HZ`, 4, alarm toggle rate. `CLK_HZ/FLASH_HZ` must be an integer ≥ 2.
- `START_W`, 10, timer preset/count width, range 4..19 (maximum display 999999).
- `LED_W`, 7, alarm LED count.
- `clk`, in, 1: the only clock. All state changes on its rising edge.
- `reset`, in, 1: asynchronous, active-high. Clears all state.
- `mode_next`, in, 1: single-cycle pulse (already debounced); advances the mode.
- `run`, in, 1: level. 1 = the active timer/stopwatch counts; 0 = paused.
- `load`, in, 1: single-cycle pulse; preload or clear the active mode.
- `preset_sec`, in, START_W: timer preload, in seconds.
- `preset_hour`, in, 5: clock hour preload.
- `preset_min`, in, 6: clock minute preload.
- `mode_led`, out, 3: one-hot. Bit 0 = TIMER, bit 1 = STOPWATCH, bit 2 = CLOCK12.
- `digits`, out, 24: six BCD digits. [23:20] is the leftmost (tens of hours), [3:0] is units of seconds.
- `done`, out, 1: timer expired flag.
- `tick`, out, 1: one-cycle pulse at TICK_HZ.
- `lights`, out, LED_W: alarm flash outputs.

## Operation
- **Reset values:**
  - mode = TIMER, `mode_led` = 3'b001.
  - Timer count = 0; stopwatch = 00:00:00; clock = 12:00:00.
  - `done` = 0, `lights` = 0, `digits` = 0, `tick` = 0, prescalers = 0, converter idle.
- **Tick prescaler:**
  - Counts 0..CLK_HZ/TICK_HZ−1 continuously; `tick` = 1 on the cycle the count wraps.
  - It runs regardless of `run`, so the clock never loses time.
- **Mode FSM:**
  - Sequence is TIMER → STOPWATCH → CLOCK12 → TIMER, one step per `mode_next` pulse.
  - Inactive modes keep their state. Timer and stopwatch hold while inactive; the clock always runs.
- **TIMER:**
  - `load`: count = `preset_sec`, `done` = 0.
  - On `tick` & `run`: if count > 0, count −1. The transition 1 → 0 sets `done` = 1.
  - At count 0 the count holds and `done` stays set until the next `load`. Loading 0 leaves `done` = 0.
- **STOPWATCH:**
  - `load`: clear to 00:00:00.
  - On `tick` & `run`: sec +1. Carry at 59 into minutes, minutes carry at 59 into hours.
  - 23:59:59 wraps to 00:00:00.
- **CLOCK12:**
  - Advances on every `tick`, ignoring `run` and the current mode. 12:59:59 → 01:00:00.
  - `load` is accepted only when the mode is CLOCK12. It sets sec = 0, min = min(`preset_min`, 59), and the hour as follows:
    - 0 → 12
    - 1..12 → unchanged
    - 13..23 → h−12
    - 24..31 → 12
- **Display:**
  - TIMER: the count is shown as a 6-digit decimal using a sequential shift-add-3 converter, one bit per cycle. The converter restarts whenever the count changes mid-conversion; `digits` is written only when a conversion completes.
  - STOPWATCH / CLOCK12: hh, mm, ss are split into tens/units and registered into `digits`.
- **Alarm:** `lights` toggles all bits at each FLASH_HZ enable while mode = TIMER and `done` = 1. Otherwise `lights` = 0.
- **Simultaneous events:**
  - `mode_next` with `load`: the mode advances and `load` is ignored.
  - `load` with `tick`: `load` wins, and the tick is dropped for the active timer/stopwatch only.
  - `reset` mid-conversion: the converter aborts and `digits` = 0.

## Timing
- `tick` is high for exactly one cycle every CLK_HZ/TICK_HZ cycles. The first pulse comes CLK_HZ/TICK_HZ cycles after reset release.
- Counters update on the cycle `tick` is high; `done` updates on the same edge as the 1 → 0 count step.
- `mode_led` updates 1 cycle after `mode_next`.
- `digits` latency:
  - STOPWATCH/CLOCK12: 1 cycle after a field change or mode change.
  - TIMER: START_W+2 cycles after the last count change.
- `lights` responds within 1 cycle of `done` clearing or the mode leaving TIMER. Its first toggle is at the next flash enable.

## Configuration
- Macro: `TIMEKEEPER_ALARM_EN`.
- Defined: flash prescaler present, and `lights` flashes as above.
- Undefined: flash prescaler not built, `lights` tied to 0, FLASH_HZ unused. `done` still behaves as specified.

## Test plan
- Params: CLK_HZ = 8, TICK_HZ = 1, FLASH_HZ = 4, START_W = 10.
- Reset release, then hold 40 cycles → `mode_led` = 001, `digits` = 0, `tick` pulses at cycles 8, 16, 24, 32, 40, clock internally at 12:00:05.
- TIMER: `load` with `preset_sec` = 3, `run` = 1 → count steps 3, 2, 1, 0 on successive ticks. `done` rises with the step to 0, and `digits` = 000000 twelve cycles later. `lights` alternates 0x7F/0x00 every 2 cycles. A following `load` clears both.
- STOPWATCH: force 23:59:58, `run` = 1, two ticks → 23:59:59 then 00:00:00. With `run` = 0 for 3 ticks the value holds.
- CLOCK12: `load` with hour = 0, min = 59 → 12:59:00. 60 ticks later → 01:00:00. `load` with hour = 13, min = 63 → 01:59:00.
- `mode_next` and `load` in the same cycle while in TIMER → mode goes to STOPWATCH, timer count unchanged. Assert `reset` mid-countdown → all outputs return to their reset values asynchronously.
- With `TIMEKEEPER_ALARM_EN` undefined, repeat the TIMER test → `done` = 1 and `lights` stays 0.
